// File: rtl/sram_responder.sv
// Board-side model of a 16-bit SRAM: stores writes, returns reads after a fixed pipeline
// latency, and waits a turnaround gap after a write before it drives the shared data bus.
module sram_responder #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int MEM_AW = 16,
  parameter int RD_LAT = 2,
  parameter int TURN   = 1
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              sram_we_n,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              dq_drive,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count,
  output logic              oor
);

  typedef enum logic [1:0] {
    ST_WRITE = 2'd0,
    ST_TURN  = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [1:0] TURN_L      = TURN[1:0];
  localparam state_t     RESET_STATE = (TURN == 0) ? ST_READ : ST_TURN;

  state_t              state_r;
  logic [1:0]          cnt_r;
  logic                first_rd_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [15:0]         wr_count_r;
  logic [15:0]         rd_count_r;
  logic                oor_r;
  logic [DATA_W-1:0]   pipe_r [RD_LAT];
  logic [DATA_W-1:0]   mem_r [2**MEM_AW];
  logic [MEM_AW-1:0]   idx_s;
  logic                rd_hit_s;

  function automatic logic addr_out_of_range(input logic [ADDR_W-1:0] addr);
    return (addr >> MEM_AW) != {ADDR_W{1'b0}};
  endfunction

  assign idx_s    = sram_addr[MEM_AW-1:0];
  assign dq_drive = (state_r == ST_READ) & sram_we_n;
  assign sram_dq  = dq_drive ? pipe_r[RD_LAT-1] : {DATA_W{1'bz}};
  assign wr_count = wr_count_r;
  assign rd_count = rd_count_r;
  assign oor      = oor_r;
  // A read is counted on entry to READ and on every change of address while reading.
  assign rd_hit_s = (state_r == ST_READ) & sram_we_n & (first_rd_r | (sram_addr != addr_r));

  // Storage array; deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (!sram_we_n) begin
      mem_r[idx_s] <= sram_dq;
    end
  end

  // Bus-direction state machine, read pipeline and activity counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r    <= RESET_STATE;
      cnt_r      <= TURN_L;
      first_rd_r <= 1'b1;
      addr_r     <= {ADDR_W{1'b0}};
      wr_count_r <= 16'd0;
      rd_count_r <= 16'd0;
      oor_r      <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_r[k] <= {DATA_W{1'b0}};
      end
    end else begin
      pipe_r[0] <= mem_r[idx_s];
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
      addr_r     <= sram_addr;
      first_rd_r <= (state_r != ST_READ);
      if (addr_out_of_range(sram_addr)) begin
        oor_r <= 1'b1;
      end else begin
        oor_r <= oor_r;
      end
      if (!sram_we_n && (wr_count_r != 16'hFFFF)) begin
        wr_count_r <= wr_count_r + 16'd1;
      end else begin
        wr_count_r <= wr_count_r;
      end
      if (rd_hit_s && (rd_count_r != 16'hFFFF)) begin
        rd_count_r <= rd_count_r + 16'd1;
      end else begin
        rd_count_r <= rd_count_r;
      end
      if (!sram_we_n) begin
        state_r <= ST_WRITE;
      end else begin
        case (state_r)
          ST_WRITE: begin
            if (TURN_L == 2'd0) begin
              state_r <= ST_READ;
            end else begin
              state_r <= ST_TURN;
              cnt_r   <= TURN_L;
            end
          end
          ST_TURN: begin
            cnt_r <= cnt_r - 2'd1;
            if (cnt_r == 2'd1) begin
              state_r <= ST_READ;
            end else begin
              state_r <= ST_TURN;
            end
          end
          ST_READ: state_r <= ST_READ;
          default: state_r <= RESET_STATE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with default parameters (RD_LAT = 2, TURN = 1, MEM_AW = 16).
module tb_sram_responder;

  logic        clock;
  logic        rst;
  logic        sram_we_n;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        dq_drive;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        oor;
  logic        tb_drive;
  logic [15:0] tb_dq;
  int          n_cmp;
  int          n_bad;
  logic [15:0] rd_base;

  assign sram_dq = tb_drive ? tb_dq : 16'bz;

  sram_responder dut (
    .clock     (clock),
    .rst       (rst),
    .sram_we_n (sram_we_n),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .dq_drive  (dq_drive),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .oor       (oor)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_word(input logic [17:0] a, input logic [15:0] d);
    sram_we_n = 1'b0;
    sram_addr = a;
    tb_dq     = d;
    tb_drive  = 1'b1;
    tick();
  endtask

  task automatic go_read(input logic [17:0] a);
    tb_drive  = 1'b0;
    sram_we_n = 1'b1;
    sram_addr = a;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    sram_we_n = 1'b1;
    sram_addr = 18'h00000;
    tb_drive  = 1'b0;
    tb_dq     = 16'h0000;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_drive", {31'd0, dq_drive}, 32'd0);
    check("reset_wr_count", {16'd0, wr_count}, 32'd0);
    check("reset_rd_count", {16'd0, rd_count}, 32'd0);
    check("reset_oor", {31'd0, oor}, 32'd0);
    tick();
    check("reset_drive_after_turn", {31'd0, dq_drive}, 32'd1);

    // Single write, then read back at the same address.
    sram_we_n = 1'b0;
    sram_addr = 18'h00010;
    tb_dq     = 16'hBEEF;
    tb_drive  = 1'b1;
    #1;
    check("we_low_releases_bus", {31'd0, dq_drive}, 32'd0);
    tick();
    check("wr_count_1", {16'd0, wr_count}, 32'd1);
    go_read(18'h00010);
    tick();
    check("turn_gap_no_drive", {31'd0, dq_drive}, 32'd0);
    tick();
    check("drive_after_turn", {31'd0, dq_drive}, 32'd1);
    check("read_beef", {16'd0, sram_dq}, 32'h0000BEEF);
    tick();
    check("rd_count_1", {16'd0, rd_count}, 32'd1);

    // Back-to-back reads of three freshly written words.
    write_word(18'h00010, 16'h1111);
    write_word(18'h00011, 16'h2222);
    write_word(18'h00012, 16'h3333);
    check("wr_count_4", {16'd0, wr_count}, 32'd4);
    go_read(18'h00010);
    tick();
    tick();
    rd_base = rd_count;
    check("rd_base", {16'd0, rd_base}, 32'd1);
    tick();
    sram_addr = 18'h00011;
    check("b2b_data_0", {16'd0, sram_dq}, 32'h00001111);
    tick();
    sram_addr = 18'h00012;
    check("b2b_data_1", {16'd0, sram_dq}, 32'h00001111);
    tick();
    check("b2b_data_2", {16'd0, sram_dq}, 32'h00002222);
    check("b2b_rd_count", {16'd0, rd_count}, 32'd4);
    tick();
    check("b2b_data_3", {16'd0, sram_dq}, 32'h00003333);
    check("b2b_rd_count_hold", {16'd0, rd_count}, 32'd4);

    // Write issued while the responder is driving.
    check("drive_before_drop", {31'd0, dq_drive}, 32'd1);
    sram_we_n = 1'b0;
    #1;
    check("drop_same_cycle", {31'd0, dq_drive}, 32'd0);
    sram_addr = 18'h00020;
    tb_dq     = 16'h5A5A;
    tb_drive  = 1'b1;
    tick();
    check("wr_count_5", {16'd0, wr_count}, 32'd5);
    go_read(18'h00020);
    tick();
    tick();
    check("read_5a5a", {16'd0, sram_dq}, 32'h00005A5A);

    // Out-of-range address aliases and sets the sticky flag.
    check("oor_clear", {31'd0, oor}, 32'd0);
    write_word(18'h10005, 16'hC3C3);
    check("oor_set", {31'd0, oor}, 32'd1);
    go_read(18'h00005);
    tick();
    tick();
    check("alias_read", {16'd0, sram_dq}, 32'h0000C3C3);
    check("oor_sticky", {31'd0, oor}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_clears_oor", {31'd0, oor}, 32'd0);
    check("rst_releases_bus", {31'd0, dq_drive}, 32'd0);
    check("rst_clears_wr_count", {16'd0, wr_count}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("mem_retained", {16'd0, sram_dq}, 32'h0000C3C3);

    // Write counter saturation.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    sram_we_n = 1'b0;
    sram_addr = 18'h00001;
    tb_dq     = 16'h0001;
    tb_drive  = 1'b1;
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    check("wr_count_pre_sat", {16'd0, wr_count}, 32'h0000FFFE);
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    check("wr_count_sat", {16'd0, wr_count}, 32'h0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Synthesizable responder for the external 16-bit SRAM port driven by the CPU's SRAM controller (`sram_we_n`, `sram_addr`, `sram_dq`). It stores write data, returns read data after a programmable pipeline latency, and enforces a bus-turnaround gap before it drives the shared data bus. Activity counters and an out-of-range flag are provided for the bench. It sits on the board side of the SRAM pins and replaces the physical chip in simulation and FPGA loop-back builds.

## Interface
- `ADDR_W`, default 18: width of the `sram_addr` port.
- `DATA_W`, default 16: width of `sram_dq`.
- `MEM_AW`, default 16: implemented words = 2^MEM_AW; requires MEM_AW ≤ ADDR_W.
- `RD_LAT`, default 2: read pipeline depth in `clock` cycles; legal range 1..4.
- `TURN`, default 1: idle cycles after `sram_we_n` rises before the responder drives the bus; legal range 0..3.
- `clock`  in  1  rising-edge clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `sram_we_n`  in  1  0 = write cycle (initiator drives `sram_dq`); 1 = read cycle.
- `sram_addr`  in  ADDR_W  word address.
- `sram_dq`  inout  DATA_W  data bus; the responder drives it only while `dq_drive` = 1, otherwise it is high-Z.
- `dq_drive`  out  1  responder is currently driving `sram_dq`.
- `wr_count`  out  16  number of write cycles sampled; saturates at 16'hFFFF.
- `rd_count`  out  16  number of read accesses counted; saturates at 16'hFFFF.
- `oor`  out  1  sticky flag: an access was made with address bits [ADDR_W-1:MEM_AW] ≠ 0.

## Operation
- Storage is 2^MEM_AW × DATA_W. The array index is `sram_addr[MEM_AW-1:0]`, so out-of-range addresses alias into the array. Memory is not cleared by reset, and reads of unwritten words return unspecified data.
- The state machine has three states: WRITE, TURN, READ.
  - Any state with `sram_we_n` = 0 at a rising edge goes to WRITE and performs `mem[idx] <= sram_dq`.
  - From WRITE with `sram_we_n` = 1: go to TURN and load the turnaround counter with TURN. When TURN = 0, go directly to READ.
  - In TURN, the counter decrements each cycle. Go to READ on the edge where the counter equals 1.
  - READ stays in READ while `sram_we_n` = 1.
- Read pipeline: a shift register of RD_LAT stages.
  - Each rising edge, stage0 <= mem[idx] using the current `sram_addr`, and stage k <= stage k-1.
  - The pipeline shifts in every state.
  - `sram_dq` outputs stage RD_LAT-1.
- `dq_drive` = (state == READ) & `sram_we_n`. The `sram_we_n` term is combinational, so a falling `sram_we_n` releases the bus in the same cycle with no registered delay.
- Write-then-read to the same address: the write commits at edge N, and the stage0 capture at edge N+1 sees the new data. No bypass is needed.
- `wr_count` increments on each edge with `sram_we_n` = 0.
- `rd_count` increments on each edge in READ where either:
  - it is the first READ cycle after TURN or WRITE, or
  - `sram_addr` differs from the address registered on the previous edge.
- `oor` is set on any edge (read or write) with nonzero upper address bits. Only reset clears it.

## Timing
- Reset values:
  - state = TURN, counter = TURN (state = READ if TURN = 0);
  - all pipeline stages = 0;
  - `wr_count` = 0, `rd_count` = 0, `oor` = 0.
- `dq_drive` after reset:
  - TURN = 0: `dq_drive` = `sram_we_n`.
  - TURN > 0: `dq_drive` = 0 for TURN cycles after `rst` deasserts.
- Read latency: an address held from edge M is reflected on `sram_dq` after edge M+RD_LAT-1, i.e. RD_LAT edges after it is first sampled.
- Write-to-drive gap: the responder drives starting TURN+1 edges after the first edge that samples `sram_we_n` = 1.
- Reset mid-access: the state machine and counters return to their reset values, and the bus is released.
- An in-flight write that has not reached a rising edge is dropped.
- Memory contents are retained across reset.

## Test plan
- Reset release (TURN = 1, `sram_we_n` = 1):
  - `dq_drive` = 0 and `sram_dq` = Z for 1 cycle, then `dq_drive` = 1;
  - `wr_count` = `rd_count` = 0, `oor` = 0.
- Write 16'hBEEF to address 18'h00010 (1 cycle, `sram_we_n` = 0), then `sram_we_n` = 1 and hold the address (RD_LAT = 2):
  - `wr_count` = 1;
  - `dq_drive` rises after TURN+1 edges;
  - `sram_dq` = 16'hBEEF once the pipeline fills;
  - `rd_count` = 1.
- Back-to-back reads of addresses 0x10, 0x11, 0x12, previously written 0x1111, 0x2222, 0x3333:
  - `sram_dq` shows 0x1111, 0x2222, 0x3333 on consecutive cycles, each RD_LAT edges after its address;
  - `rd_count` increases by 3.
- Drop `sram_we_n` to 0 while in READ:
  - `dq_drive` falls in the same cycle (no bus contention);
  - the write of 16'h5A5A commits and `wr_count` increments.
- Write to 18'h10005 with MEM_AW = 16:
  - `oor` = 1 and stays 1;
  - a read of 18'h00005 returns the written value (aliasing);
  - asserting `rst` clears `oor`.
- Write count saturation: 65 540 consecutive write cycles leave `wr_count` = 16'hFFFF, with no wrap to 0.
